// File: rtl/shift_pipe.sv
// Two-stage pipelined 32-bit shifter (SLL/SRL/SRA/pass) with valid/ready handshake.
// Stage 1 applies the 16/8-bit shift levels, stage 2 applies the 4/2/1-bit levels.
module shift_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [4:0]       in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_data_q,  s1_data_d;
    logic [2:0]       s1_amt_q,   s1_amt_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic             s1_sign_q,  s1_sign_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q,  s2_data_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [4:0]       amt_hi;
    logic [31:0]      sh1;
    logic [31:0]      sh2;
    logic [63:0]      sra_wide;

    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        amt_hi = {in_amt[4:3], 3'b000};
        case (in_op)
            OP_SLL:  sh1 = in_data << amt_hi;
            OP_SRL:  sh1 = in_data >> amt_hi;
            OP_SRA:  sh1 = $unsigned($signed(in_data) >>> amt_hi);
            default: sh1 = in_data;
        endcase

        // SRA fill comes from the original operand sign, not the partially shifted value.
        sra_wide = {{32{s1_sign_q}}, s1_data_q} >> s1_amt_q;
        case (s1_op_q)
            OP_SLL:  sh2 = s1_data_q << s1_amt_q;
            OP_SRL:  sh2 = s1_data_q >> s1_amt_q;
            OP_SRA:  sh2 = sra_wide[31:0];
            default: sh2 = s1_data_q;
        endcase

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_amt_d   = s1_amt_q;
        s1_op_d    = s1_op_q;
        s1_sign_d  = s1_sign_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_tag_d   = s2_tag_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sh2;
                s2_tag_d  = s1_tag_q;
            end
        end

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = sh1;
                s1_amt_d  = in_amt[2:0];
                s1_op_d   = in_op;
                s1_sign_d = in_data[31];
                s1_tag_d  = in_tag;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_amt_q   <= '0;
            s1_op_q    <= '0;
            s1_sign_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_amt_q   <= s1_amt_d;
            s1_op_q    <= s1_op_d;
            s1_sign_q  <= s1_sign_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign in_ready  = s1_adv && reset;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: shift results, latency, back-to-back flow,
// backpressure and mid-operation reset, with hand-computed expectations.
module tb_shift_pipe;

    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [4:0]       in_amt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    int n_checks = 0;
    int n_pass   = 0;

    shift_pipe #(.TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] amt, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_amt   = amt;
        in_tag   = tag;
    endtask

    // One isolated op: accepted at the next edge, result visible after the following edge.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] amt, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp);
        out_ready = 1'b1;
        drive(1'b1, op, d, amt, tag);
        check({name, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, '0);
        check({name, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check({name, "_vld"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        tick();
        check({name, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0, '0);
        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  out_data, 32'h0);
        check("rst_out_tag",   32'(out_tag), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready",  32'(in_ready), 32'd1);

        run_op("srl31",   2'b01, 32'h8000_0000, 5'd31, 5'd7,  32'h0000_0001);
        run_op("sll31",   2'b00, 32'h0000_0001, 5'd31, 5'd8,  32'h8000_0000);
        run_op("sra4",    2'b10, 32'h8000_0000, 5'd4,  5'd9,  32'hF800_0000);
        run_op("sra20",   2'b10, 32'h8000_0000, 5'd20, 5'd10, 32'hFFFF_F800);
        run_op("sra31p",  2'b10, 32'h7FFF_FFFF, 5'd31, 5'd11, 32'h0000_0000);
        run_op("srl0",    2'b01, 32'hDEAD_BEEF, 5'd0,  5'd12, 32'hDEAD_BEEF);
        run_op("pass9",   2'b11, 32'h1234_5678, 5'd9,  5'd13, 32'h1234_5678);
        run_op("sll12",   2'b00, 32'h0000_00FF, 5'd12, 5'd14, 32'h000F_F000);
        run_op("sra5p",   2'b10, 32'h4000_0000, 5'd5,  5'd15, 32'h0200_0000);
        run_op("sra0n",   2'b10, 32'h8000_0001, 5'd0,  5'd31, 32'h8000_0001);

        // Back-to-back tags 1,2,3
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd1, 5'd1);
        tick();
        drive(1'b1, 2'b01, 32'h0000_0100, 5'd4, 5'd2);
        check("b2b_gap", 32'(out_valid), 32'd0);
        tick();
        check("b2b1_vld",  32'(out_valid), 32'd1);
        check("b2b1_data", out_data, 32'h0000_0002);
        check("b2b1_tag",  32'(out_tag), 32'd1);
        drive(1'b1, 2'b10, 32'hF000_0000, 5'd8, 5'd3);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, '0);
        check("b2b2_vld",  32'(out_valid), 32'd1);
        check("b2b2_data", out_data, 32'h0000_0010);
        check("b2b2_tag",  32'(out_tag), 32'd2);
        tick();
        check("b2b3_vld",  32'(out_valid), 32'd1);
        check("b2b3_data", out_data, 32'hFFF0_0000);
        check("b2b3_tag",  32'(out_tag), 32'd3);
        tick();
        check("b2b_end", 32'(out_valid), 32'd0);

        // Backpressure: out_ready low across four edges
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0003, 5'd2, 5'd4);
        check("bp_rdy0", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 2'b01, 32'h0000_00F0, 5'd4, 5'd5);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 2'b11, 32'hCAFE_F00D, 5'd3, 5'd6);
        check("bp_full_vld",  32'(out_valid), 32'd1);
        check("bp_full_data", out_data, 32'h0000_000C);
        check("bp_full_rdy",  32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_hold_data", out_data, 32'h0000_000C);
            check("bp_hold_tag",  32'(out_tag), 32'd4);
            check("bp_hold_rdy",  32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_comb_rdy", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 2'b00, 32'h0, 5'd0, '0);
        check("bp_b_data", out_data, 32'h0000_000F);
        check("bp_b_tag",  32'(out_tag), 32'd5);
        tick();
        check("bp_c_vld",  32'(out_valid), 32'd1);
        check("bp_c_data", out_data, 32'hCAFE_F00D);
        check("bp_c_tag",  32'(out_tag), 32'd6);
        tick();
        check("bp_end", 32'(out_valid), 32'd0);

        // Reset with two ops in flight
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd3, 5'd20);
        tick();
        drive(1'b1, 2'b00, 32'h0000_0001, 5'd5, 5'd21);
        tick();
        check("mr_full_vld", 32'(out_valid), 32'd1);
        drive(1'b0, 2'b00, 32'h0, 5'd0, '0);
        reset = 1'b0;
        tick();
        check("mr_vld",  32'(out_valid), 32'd0);
        check("mr_data", out_data, 32'h0);
        check("mr_rdy",  32'(in_ready), 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mr_rel_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_ghost", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
